// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and constants for the five-stage RISC-V core control blocks.
package riscv_pipe_pkg;

    localparam int unsigned RISCV_REG_ADDR_W = 5;
    localparam int unsigned HZ_CNT_W         = 4;

    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        LOAD_STALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_load_use_cmp.sv
// Load-use hazard compare: a load in EX writes a register the ID instruction really reads (x0 excluded).
module hazard_load_use_cmp
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = RISCV_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  hazard_c
);

    logic rs1_match;
    logic rs2_match;

    always_comb begin
        rs1_match = id_rs1_used && (id_rs1 == ex_rd);
        rs2_match = id_rs2_used && (id_rs2 == ex_rd);
        hazard_c  = ex_mem_read && (ex_rd != '0) && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: multi-cycle load-use stall, memory-busy freeze and branch flush.
// Optional HAZARD_PERF_EN adds saturating stall/flush performance counters.
module hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W        = RISCV_REG_ADDR_W,
    parameter int unsigned LOAD_STALL_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_busy,
    input  logic                  branch_taken,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_write_en,
    output logic                  if_id_flush,
    output logic                  stall_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
`endif
);

    localparam logic [HZ_CNT_W-1:0] CNT_INIT = HZ_CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [HZ_CNT_W-1:0] CNT_ONE  = HZ_CNT_W'(1);

    if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 15) begin : g_bad_cfg
        $error("hazard_ctrl: LOAD_STALL_CYCLES must be in 1..15");
    end

    hz_state_t             state_q, state_d;
    logic [HZ_CNT_W-1:0]   cnt_q, cnt_d;
    logic                  hazard_c;

    hazard_load_use_cmp #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_cmp (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .hazard_c    (hazard_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Priority: freeze > flush > ongoing stall > new hazard.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pc_write_en     = 1'b1;
        if_id_write_en  = 1'b1;
        ex_mem_write_en = 1'b1;
        id_ex_bubble    = 1'b0;
        if_id_flush     = 1'b0;
        stall_busy      = 1'b0;
        if (mem_busy) begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            ex_mem_write_en = 1'b0;
            stall_busy      = (state_q == LOAD_STALL);
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = IDLE;
            cnt_d        = '0;
        end else if (state_q == LOAD_STALL) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
            stall_busy     = 1'b1;
            if (cnt_q == CNT_ONE) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else if (hazard_c) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
            stall_busy     = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_d = LOAD_STALL;
                cnt_d   = CNT_INIT;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    localparam int unsigned PERF_W = 32;

    logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
    logic [PERF_W-1:0] perf_flush_q, perf_flush_d;
    logic              stall_evt_c;

    // Load-use stall cycles only; memory freeze also drops pc_write_en but is excluded.
    always_comb begin
        stall_evt_c  = !pc_write_en && !mem_busy;
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stall_evt_c && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + PERF_W'(1);
        end
        if (if_id_flush && (perf_flush_q != '1)) begin
            perf_flush_d = perf_flush_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: three instances (1, 3 and 4 stall cycles) share one stimulus stream.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_mem_read, mem_busy, branch_taken;

    // Output vectors: {pc_write_en, if_id_write_en, id_ex_bubble, ex_mem_write_en, if_id_flush, stall_busy}
    wire [5:0]  o1, o3, o4;
    wire [31:0] ps1, ps3, ps4, pf1, pf3, pf4;

    typedef struct packed {
        logic [5:0]  o1, o3, o4;
        logic [31:0] ps1, ps3, ps4, pf1, pf3, pf4;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    int          lsc [3] = '{1, 3, 4};
    bit          m_st [3];
    int          m_left [3];
    logic [31:0] m_ps [3];
    logic [31:0] m_pf [3];

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_busy(mem_busy),
        .branch_taken(branch_taken), .pc_write_en(o1[5]), .if_id_write_en(o1[4]),
        .id_ex_bubble(o1[3]), .ex_mem_write_en(o1[2]), .if_id_flush(o1[1]),
        .stall_busy(o1[0])
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(ps1), .perf_flush_cnt(pf1)
`endif
    );

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_busy(mem_busy),
        .branch_taken(branch_taken), .pc_write_en(o3[5]), .if_id_write_en(o3[4]),
        .id_ex_bubble(o3[3]), .ex_mem_write_en(o3[2]), .if_id_flush(o3[1]),
        .stall_busy(o3[0])
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(ps3), .perf_flush_cnt(pf3)
`endif
    );

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_busy(mem_busy),
        .branch_taken(branch_taken), .pc_write_en(o4[5]), .if_id_write_en(o4[4]),
        .id_ex_bubble(o4[3]), .ex_mem_write_en(o4[2]), .if_id_flush(o4[1]),
        .stall_busy(o4[0])
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(ps4), .perf_flush_cnt(pf4)
`endif
    );

`ifndef HAZARD_PERF_EN
    assign ps1 = '0; assign ps3 = '0; assign ps4 = '0;
    assign pf1 = '0; assign pf3 = '0; assign pf4 = '0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and push what the reference model expects for it.
    task automatic cycle(input logic rn, input logic mr, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic busy, input logic br);
        exp_t       e;
        logic [5:0] o [3];
        logic       hz;
        @(posedge clk);
        #1;
        rst_n = rn; ex_mem_read = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_rs1_used = u1; id_rs2_used = u2; mem_busy = busy; branch_taken = br;
        hz = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        for (int i = 0; i < 3; i++) begin
            if (!rn) begin
                m_st[i] = 1'b0; m_left[i] = 0; m_ps[i] = '0; m_pf[i] = '0;
            end
        end
        e.ps1 = m_ps[0]; e.ps3 = m_ps[1]; e.ps4 = m_ps[2];
        e.pf1 = m_pf[0]; e.pf3 = m_pf[1]; e.pf4 = m_pf[2];
        for (int i = 0; i < 3; i++) begin
            if (busy) begin
                o[i] = {5'b00000, m_st[i]};
            end else if (br) begin
                o[i] = 6'b111110;
                m_st[i] = 1'b0; m_left[i] = 0;
                m_pf[i] = m_pf[i] + 32'd1;
            end else if (m_st[i]) begin
                o[i] = 6'b001101;
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) m_st[i] = 1'b0;
                m_ps[i] = m_ps[i] + 32'd1;
            end else if (hz) begin
                o[i] = 6'b001101;
                m_left[i] = lsc[i] - 1;
                m_st[i] = (m_left[i] > 0);
                m_ps[i] = m_ps[i] + 32'd1;
            end else begin
                o[i] = 6'b110100;
            end
            if (!rn) begin
                m_st[i] = 1'b0; m_left[i] = 0; m_ps[i] = '0; m_pf[i] = '0;
            end
        end
        e.o1 = o[0]; e.o3 = o[1]; e.o4 = o[2];
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_use(input logic busy, input logic br);
        cycle(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, busy, br);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("dut1_outs", 32'(o1), 32'(e.o1));
            check_eq("dut3_outs", 32'(o3), 32'(e.o3));
            check_eq("dut4_outs", 32'(o4), 32'(e.o4));
`ifdef HAZARD_PERF_EN
            check_eq("dut1_perf_stall", ps1, e.ps1);
            check_eq("dut3_perf_stall", ps3, e.ps3);
            check_eq("dut4_perf_stall", ps4, e.ps4);
            check_eq("dut1_perf_flush", pf1, e.pf1);
            check_eq("dut3_perf_flush", pf3, e.pf3);
            check_eq("dut4_perf_flush", pf4, e.pf4);
`endif
        end
    end

    initial begin
        rst_n = 1'b0; ex_mem_read = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; mem_busy = 1'b0; branch_taken = 1'b0;

        // Reset with quiet inputs
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Plain load-use stall: 1, 3 and 4 cycles
        load_use(1'b0, 1'b0);
        idle(6);

        // x0 destination, unused rs2, then a real rs2 hazard
        cycle(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        cycle(1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(5);

        // Memory freeze during the second stall cycle
        load_use(1'b0, 1'b0);
        cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(6);

        // Branch in the second stall cycle
        load_use(1'b0, 1'b0);
        cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(5);

        // Branch together with hazard, and hazard while memory is busy
        load_use(1'b0, 1'b1);
        idle(3);
        load_use(1'b1, 1'b0);
        idle(2);

        // Reset in the middle of a stall
        load_use(1'b0, 1'b0);
        idle(1);
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(6);

        // Random traffic over a small register range
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 99) >= 2) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0);
        end
        idle(2);

        @(negedge clk);
        #1;
        check_eq("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
